sva_sampled_value_tracker: RTL

// Hardware sampled-value monitor feeding assertion checkers downstream. Keeps a 4-state
// (value + unknown-mask) history of one signal per qualified clock edge. Produces registered
// $rose/$fell/$stable/$changed flags and a $past(val,DEPTH) tap, plus saturating event counters.
// X is carried explicitly as xmask (1 = bit unknown), so the semantics are synthesizable.

---
 rtl/sva_sampled_value_tracker.sv | 100 ++++++++++
 1 files changed

// File: rtl/sva_sampled_value_tracker.sv
// sva_sampled_value_tracker: 4-state sampled-value history with registered $rose/$fell/$stable/$changed,
// a $past(val,DEPTH) tap and saturating rose/fell event counters.
module sva_sampled_value_tracker #(
  parameter int               WIDTH    = 3,
  parameter int               DEPTH    = 2,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter logic [WIDTH-1:0] INIT_XM  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] xmask,
  input  logic             clear,
  output logic             flag_valid,
  output logic             rose,
  output logic             fell,
  output logic             stable,
  output logic             changed,
  output logic [WIDTH-1:0] past_val,
  output logic [WIDTH-1:0] past_xmask,
  output logic             history_valid,
  output logic [CNT_W-1:0] rose_cnt,
  output logic [CNT_W-1:0] fell_cnt,
  output logic             x_seen
);
  localparam int FW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] hist_v_q [DEPTH];
  logic [WIDTH-1:0] hist_v_d [DEPTH];
  logic [WIDTH-1:0] hist_x_q [DEPTH];
  logic [WIDTH-1:0] hist_x_d [DEPTH];
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] rose_cnt_q, rose_cnt_d, fell_cnt_q, fell_cnt_d;
  logic             flag_valid_q, flag_valid_d, rose_q, rose_d, fell_q, fell_d;
  logic             stable_q, stable_d, x_seen_q, x_seen_d;
  logic             prev_k1, prev_k0, rose_c, fell_c, stable_c;
  // X is compared as its own symbol: equal masks plus equal values on known bits
  always_comb begin
    prev_k1      = !hist_x_q[0][0] && hist_v_q[0][0];
    prev_k0      = !hist_x_q[0][0] && !hist_v_q[0][0];
    rose_c       = !xmask[0] && val[0] && !prev_k1;
    fell_c       = !xmask[0] && !val[0] && !prev_k0;
    stable_c     = (xmask == hist_x_q[0]) && (((val ^ hist_v_q[0]) & ~xmask) == '0);
    flag_valid_d = sample_en;
    rose_d       = sample_en ? rose_c : rose_q;
    fell_d       = sample_en ? fell_c : fell_q;
    stable_d     = sample_en ? stable_c : stable_q;
    fill_d       = (sample_en && fill_q != FW'(DEPTH)) ? fill_q + FW'(1) : fill_q;
    rose_cnt_d   = clear ? '0 : (sample_en && rose_c && rose_cnt_q != '1) ? rose_cnt_q + CNT_W'(1) : rose_cnt_q;
    fell_cnt_d   = clear ? '0 : (sample_en && fell_c && fell_cnt_q != '1) ? fell_cnt_q + CNT_W'(1) : fell_cnt_q;
    x_seen_d     = !clear && (x_seen_q || (sample_en && |xmask));
    hist_v_d     = hist_v_q;
    hist_x_d     = hist_x_q;
    if (sample_en) begin
      hist_v_d[0] = val;
      hist_x_d[0] = xmask;
      for (int i = 1; i < DEPTH; i++) begin
        hist_v_d[i] = hist_v_q[i-1];
        hist_x_d[i] = hist_x_q[i-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v_q     <= '{default: INIT_VAL};
      hist_x_q     <= '{default: INIT_XM};
      fill_q       <= '0;
      flag_valid_q <= 1'b0;
      rose_q       <= 1'b0;
      fell_q       <= 1'b0;
      stable_q     <= 1'b1;
      rose_cnt_q   <= '0;
      fell_cnt_q   <= '0;
      x_seen_q     <= 1'b0;
    end else begin
      hist_v_q     <= hist_v_d;
      hist_x_q     <= hist_x_d;
      fill_q       <= fill_d;
      flag_valid_q <= flag_valid_d;
      rose_q       <= rose_d;
      fell_q       <= fell_d;
      stable_q     <= stable_d;
      rose_cnt_q   <= rose_cnt_d;
      fell_cnt_q   <= fell_cnt_d;
      x_seen_q     <= x_seen_d;
    end
  end
  assign flag_valid    = flag_valid_q;
  assign rose          = rose_q;
  assign fell          = fell_q;
  assign stable        = stable_q;
  assign changed       = ~stable_q;
  assign past_val      = hist_v_q[DEPTH-1];
  assign past_xmask    = hist_x_q[DEPTH-1];
  assign history_valid = fill_q == FW'(DEPTH);
  assign rose_cnt      = rose_cnt_q;
  assign fell_cnt      = fell_cnt_q;
  assign x_seen        = x_seen_q;
endmodule
